// File: rtl/fault_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// fault_recovery_ctrl
//   Supervisory sequencer for the fault detector protection datapath.
//   It holds the detector in reset, then powers the load with a start-up
//   blanking window. After a shutdown it waits a hold-off time and retries
//   automatically. Too many failed attempts in a row latch a lockout that only
//   an operator acknowledge can clear.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   enable         in   level, 1 = operate the load, 0 = turn it off
//   det_shutdown   in   shutdown output of the fault detector
//   det_fault      in   fault output of the fault detector
//   clear_lockout  in   1-cycle operator acknowledge of a lockout
//   det_rstn       out  active-low reset to the fault detector
//   power_en       out  load power switch enable
//   blank          out  start-up blanking window active
//   lockout        out  latched lockout indication
//   retry_cnt      out  failed attempts since the last clean period
//   state          out  OFF=0 START=1 SETTLE=2 RUN=3 HOLDOFF=4 LOCKOUT=5
// -----------------------------------------------------------------------------
module fault_recovery_ctrl #(
    parameter int RST_CYC     = 2,
    parameter int BLANK_CYC   = 8,
    parameter int HOLDOFF_CYC = 16,
    parameter int STABLE_CYC  = 64,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       det_shutdown,
    input  logic       det_fault,
    input  logic       clear_lockout,
    output logic       det_rstn,
    output logic       power_en,
    output logic       blank,
    output logic       lockout,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    // One shared up-counting timer, sized for the longest interval.
    localparam int MAX_A = (RST_CYC > BLANK_CYC) ? RST_CYC : BLANK_CYC;
    localparam int MAX_B = (MAX_A > HOLDOFF_CYC) ? MAX_A : HOLDOFF_CYC;
    localparam int MAX_C = (MAX_B > STABLE_CYC) ? MAX_B : STABLE_CYC;
    localparam int TW    = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] BLANK_LAST  = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] HOLDOFF_LAST = TW'(HOLDOFF_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    // Moore output decode helpers, applied to the next state so the
    // registered outputs always match the state register.
    function automatic logic dec_det_rstn(input state_t s);
        return (s == ST_SETTLE) || (s == ST_RUN);
    endfunction

    function automatic logic dec_power_en(input state_t s);
        return (s == ST_SETTLE) || (s == ST_RUN);
    endfunction

    function automatic logic dec_blank(input state_t s);
        return (s == ST_SETTLE);
    endfunction

    function automatic logic dec_lockout(input state_t s);
        return (s == ST_LOCKOUT);
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [3:0]    retry_r;
    logic [3:0]    retry_nxt_s;
    logic          det_rstn_r;
    logic          power_en_r;
    logic          blank_r;
    logic          lockout_r;

    // Next-state, timer and retry counter computation.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r + TIMER_ONE;
        retry_nxt_s = retry_r;
        if ((state_r != ST_LOCKOUT) && !enable) begin
            // Dropping enable aborts any sequence except a latched lockout.
            state_nxt_s = ST_OFF;
            timer_nxt_s = TIMER_ZERO;
            retry_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    // Only reachable here with enable high.
                    state_nxt_s = ST_START;
                    timer_nxt_s = TIMER_ZERO;
                end
                ST_START: begin
                    if (timer_r == RST_LAST) begin
                        state_nxt_s = ST_SETTLE;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_SETTLE: begin
                    // det_fault is blanked here; only a shutdown counts.
                    if (det_shutdown) begin
                        timer_nxt_s = TIMER_ZERO;
                        if (retry_r == RETRY_MAX) begin
                            state_nxt_s = ST_LOCKOUT;
                        end else begin
                            state_nxt_s = ST_HOLDOFF;
                            retry_nxt_s = retry_r + 4'd1;
                        end
                    end else if (timer_r == BLANK_LAST) begin
                        state_nxt_s = ST_RUN;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end
                ST_RUN: begin
                    // A fault on the same edge as the clean-period expiry wins.
                    if (det_shutdown || det_fault) begin
                        timer_nxt_s = TIMER_ZERO;
                        if (retry_r == RETRY_MAX) begin
                            state_nxt_s = ST_LOCKOUT;
                        end else begin
                            state_nxt_s = ST_HOLDOFF;
                            retry_nxt_s = retry_r + 4'd1;
                        end
                    end else if (timer_r == STABLE_LAST) begin
                        timer_nxt_s = TIMER_ZERO;
                        retry_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_r == HOLDOFF_LAST) begin
                        state_nxt_s = ST_START;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        state_nxt_s = ST_HOLDOFF;
                    end
                end
                ST_LOCKOUT: begin
                    timer_nxt_s = TIMER_ZERO;
                    if (clear_lockout) begin
                        state_nxt_s = ST_OFF;
                        retry_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_LOCKOUT;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    timer_nxt_s = TIMER_ZERO;
                    retry_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_OFF;
            timer_r    <= TIMER_ZERO;
            retry_r    <= 4'd0;
            det_rstn_r <= 1'b0;
            power_en_r <= 1'b0;
            blank_r    <= 1'b0;
            lockout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            retry_r    <= retry_nxt_s;
            det_rstn_r <= dec_det_rstn(state_nxt_s);
            power_en_r <= dec_power_en(state_nxt_s);
            blank_r    <= dec_blank(state_nxt_s);
            lockout_r  <= dec_lockout(state_nxt_s);
        end
    end

    assign det_rstn  = det_rstn_r;
    assign power_en  = power_en_r;
    assign blank     = blank_r;
    assign lockout   = lockout_r;
    assign retry_cnt = retry_r;
    assign state     = state_r;

endmodule
